// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares the single-ported memory bus between instruction fetch and the data side.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate via a last-grant register instead of data-first priority.
//
// state     | meaning
// IDLE      | sample requests, latch the winner's transaction into the bus registers
// ISSUE     | busRequest and all bus outputs held until busAccept
// WAIT_RESP | wait for busResponseValid, capture read data for the owner
// RESPOND   | one-cycle completion pulse to the owner, requests ignored
module memory_port_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  input  logic        fetchKill,
  output logic [31:0] fetchInstruction,
  output logic        fetchValid,
  input  logic        dataReadRequest,
  input  logic        storeValid,
  input  logic [31:0] addressRegister,
  input  logic [31:0] storeData,
  input  logic [3:0]  realStoreByteEnable,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        busRequest,
  output logic        busWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  output logic [3:0]  busByteEnable,
  input  logic        busAccept,
  input  logic [31:0] busReadData,
  input  logic        busResponseValid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;

  state_t state, state_next;
  owner_t owner;
  logic   killed;
  logic   data_req, fetch_req, tie_to_fetch;
  logic   grant_data, grant_fetch;

  assign data_req  = storeValid | dataReadRequest;
  // A kill in the same cycle as the request withdraws it before it can be granted.
  assign fetch_req = fetchRequest & ~fetchKill;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= FETCH;
    end else if (grant_data) begin
      last_grant <= DATA;
    end else if (grant_fetch) begin
      last_grant <= FETCH;
    end
  end

  assign tie_to_fetch = (last_grant == DATA);
`else
  assign tie_to_fetch = 1'b0;
`endif

  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state == IDLE) begin
      grant_data  = data_req && !(fetch_req && tie_to_fetch);
      grant_fetch = fetch_req && !grant_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant_data || grant_fetch) state_next = ISSUE;
      ISSUE:     if (busAccept) state_next = WAIT_RESP;
      WAIT_RESP: if (busResponseValid) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner            <= FETCH;
      killed           <= 1'b0;
      busRequest       <= 1'b0;
      busWrite         <= 1'b0;
      busAddress       <= 32'h0;
      busWriteData     <= 32'h0;
      busByteEnable    <= 4'h0;
      fetchInstruction <= 32'h0;
      loadData         <= 32'h0;
      fetchValid       <= 1'b0;
      loadDataValid    <= 1'b0;
      storeComplete    <= 1'b0;
    end else begin
      fetchValid    <= 1'b0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;

      if (state != IDLE && owner == FETCH && fetchKill) begin
        killed <= 1'b1;
      end

      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (grant_data) begin
            owner         <= DATA;
            busRequest    <= 1'b1;
            busWrite      <= storeValid;
            busAddress    <= addressRegister;
            busWriteData  <= storeValid ? storeData : 32'h0;
            busByteEnable <= storeValid ? realStoreByteEnable : 4'b1111;
          end else if (grant_fetch) begin
            owner         <= FETCH;
            busRequest    <= 1'b1;
            busWrite      <= 1'b0;
            busAddress    <= fetchAddress;
            busWriteData  <= 32'h0;
            busByteEnable <= 4'b1111;
          end
        end
        ISSUE: begin
          if (busAccept) begin
            busRequest <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (busResponseValid) begin
            if (owner == FETCH) begin
              fetchInstruction <= busReadData;
              // The pulse is registered here, so a kill arriving this cycle must be folded in now.
              fetchValid       <= !(killed || fetchKill);
            end else if (busWrite) begin
              storeComplete <= 1'b1;
            end else begin
              loadData      <= busReadData;
              loadDataValid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: bus model with programmable stalls plus a completion scoreboard.
`timescale 1ns/1ps
module tb_memory_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchRequest, fetchKill, dataReadRequest, storeValid;
  logic [31:0] fetchAddress, addressRegister, storeData;
  logic [3:0]  realStoreByteEnable;
  logic [31:0] fetchInstruction, loadData;
  logic        fetchValid, loadDataValid, storeComplete;
  logic        busRequest, busWrite;
  logic [31:0] busAddress, busWriteData;
  logic [3:0]  busByteEnable;
  logic        busAccept, busResponseValid;
  logic [31:0] busReadData;

  memory_port_arbiter dut (
    .clock(clock), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .fetchKill(fetchKill),
    .fetchInstruction(fetchInstruction), .fetchValid(fetchValid),
    .dataReadRequest(dataReadRequest), .storeValid(storeValid),
    .addressRegister(addressRegister), .storeData(storeData),
    .realStoreByteEnable(realStoreByteEnable),
    .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete),
    .busRequest(busRequest), .busWrite(busWrite), .busAddress(busAddress),
    .busWriteData(busWriteData), .busByteEnable(busByteEnable),
    .busAccept(busAccept), .busReadData(busReadData), .busResponseValid(busResponseValid)
  );

  always #5 clock = ~clock;

  typedef struct { int kind; logic [31:0] data; } exp_t;  // kind 0=fetch 1=load 2=store
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int fetch_pulses = 0, load_pulses = 0, store_pulses = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0000_0013;
      32'h10:  return 32'hDEAD_BEEF;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  // bus model
  int          accept_delay = 0, resp_delay = 0;
  bit          stray = 0;
  int          stall_cnt = 0, wait_cnt = 0;
  bit          pend = 0;
  logic [31:0] acc_addr;
  logic        acc_write;

  initial begin
    busAccept = 1'b0;
    busResponseValid = 1'b0;
    busReadData = 32'h0;
  end

  always @(posedge clock) begin
    #1;
    busAccept = 1'b0;
    busResponseValid = 1'b0;
    if (reset) begin
      pend = 0;
      stall_cnt = 0;
      wait_cnt = 0;
    end else if (stray) begin
      stray = 0;
      busResponseValid = 1'b1;
      busReadData = 32'hBAD0_BAD0;
    end else if (pend) begin
      if (wait_cnt == resp_delay) begin
        busResponseValid = 1'b1;
        busReadData = acc_write ? 32'h0 : mem_word(acc_addr);
        pend = 0;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else if (busRequest) begin
      if (stall_cnt == accept_delay) begin
        busAccept = 1'b1;
        acc_addr = busAddress;
        acc_write = busWrite;
        stall_cnt = 0;
        pend = 1;
        wait_cnt = 0;
      end else begin
        stall_cnt++;
      end
    end
  end

  // scoreboard monitor
  int          mon_k;
  logic [31:0] mon_d;
  exp_t        mon_e;

  always @(negedge clock) begin
    if (!reset && (fetchValid || loadDataValid || storeComplete)) begin
      mon_k = fetchValid ? 0 : (loadDataValid ? 1 : 2);
      mon_d = fetchValid ? fetchInstruction : (loadDataValid ? loadData : 32'h0);
      total++;
      if ($countones({fetchValid, loadDataValid, storeComplete}) != 1) begin
        bad++;
        $display("FAIL pulse_count got=%b required exactly one", {fetchValid, loadDataValid, storeComplete});
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse kind=%0d data=%h required none", mon_k, mon_d);
      end else begin
        mon_e = sb.pop_front();
        if (mon_k !== mon_e.kind || mon_d !== mon_e.data) begin
          bad++;
          $display("FAIL response kind=%0d data=%h required kind=%0d data=%h", mon_k, mon_d, mon_e.kind, mon_e.data);
        end
      end
    end
    if (fetchValid) fetch_pulses++;
    if (loadDataValid) load_pulses++;
    if (storeComplete) store_pulses++;
  end

  // requesters drop their level once completed
  always @(negedge clock) begin
    if (fetchValid) fetchRequest = 1'b0;
    if (loadDataValid) dataReadRequest = 1'b0;
    if (storeComplete) storeValid = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d required 0", name, sb.size());
      sb.delete();
    end
    step(2);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busRequest, busWrite, busAddress, busWriteData, busByteEnable} !== 70'h0) begin
      bad++;
      $display("FAIL reset_bus got=%b %b %h %h %b required all zero", busRequest, busWrite, busAddress, busWriteData, busByteEnable);
    end
    total++;
    if ({fetchInstruction, loadData, fetchValid, loadDataValid, storeComplete} !== 67'h0) begin
      bad++;
      $display("FAIL reset_resp got=%h %h %b%b%b required all zero", fetchInstruction, loadData, fetchValid, loadDataValid, storeComplete);
    end
    @(negedge clock);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_fetch_only();
    fetchAddress = 32'h100;
    fetchRequest = 1'b1;
    sb.push_back(exp_t'{0, 32'h0000_0013});
    @(negedge clock);
    total++;
    if (busRequest !== 1'b0) begin
      bad++;
      $display("FAIL fetch_c0_busreq got=%b required 0", busRequest);
    end
    @(negedge clock);
    total++;
    if ({busRequest, busWrite, busAddress, busByteEnable} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
      bad++;
      $display("FAIL fetch_c1_bus got=%b %b %h %b required 1 0 00000100 1111", busRequest, busWrite, busAddress, busByteEnable);
    end
    @(negedge clock);
    total++;
    if (busRequest !== 1'b0 || fetchValid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_c2 busRequest=%b fetchValid=%b required 0 0", busRequest, fetchValid);
    end
    @(negedge clock);
    total++;
    if (fetchValid !== 1'b1 || fetchInstruction !== 32'h0000_0013) begin
      bad++;
      $display("FAIL fetch_c3 fetchValid=%b data=%h required 1 00000013", fetchValid, fetchInstruction);
    end
    wait_drain("fetch_only", 10);
  endtask

  task automatic test_store_stall();
    int sp, lp;
    sp = store_pulses;
    lp = load_pulses;
    accept_delay = 2;
    addressRegister = 32'h202;
    storeData = 32'h00AB_0000;
    realStoreByteEnable = 4'b0100;
    storeValid = 1'b1;
    sb.push_back(exp_t'{2, 32'h0});
    @(negedge clock);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      total++;
      if ({busRequest, busWrite, busAddress, busWriteData, busByteEnable} !== {1'b1, 1'b1, 32'h202, 32'h00AB_0000, 4'b0100}) begin
        bad++;
        $display("FAIL store_stall_c%0d got=%b %b %h %h %b required 1 1 00000202 00ab0000 0100", c, busRequest, busWrite, busAddress, busWriteData, busByteEnable);
      end
    end
    @(negedge clock);
    total++;
    if (busRequest !== 1'b0) begin
      bad++;
      $display("FAIL store_after_accept busRequest=%b required 0", busRequest);
    end
    @(negedge clock);
    total++;
    if (storeComplete !== 1'b1) begin
      bad++;
      $display("FAIL store_complete_c5 got=%b required 1", storeComplete);
    end
    wait_drain("store", 10);
    total++;
    if (store_pulses - sp != 1 || load_pulses - lp != 0) begin
      bad++;
      $display("FAIL store_pulses store=%0d load=%0d required 1 0", store_pulses - sp, load_pulses - lp);
    end
    accept_delay = 0;
    realStoreByteEnable = 4'b0000;
  endtask

  task automatic test_tie();
    addressRegister = 32'h300;
    dataReadRequest = 1'b1;
    sb.push_back(exp_t'{1, mem_word(32'h300)});
    wait_drain("tie_pre_load", 10);
    fetchAddress = 32'h200;
    addressRegister = 32'h340;
    fetchRequest = 1'b1;
    dataReadRequest = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    sb.push_back(exp_t'{0, mem_word(32'h200)});
    sb.push_back(exp_t'{1, mem_word(32'h340)});
`else
    sb.push_back(exp_t'{1, mem_word(32'h340)});
    sb.push_back(exp_t'{0, mem_word(32'h200)});
`endif
    @(negedge clock);
    @(negedge clock);
    total++;
`ifdef ARB_ROUND_ROBIN_EN
    if (busAddress !== 32'h200) begin
      bad++;
      $display("FAIL tie_first_grant addr=%h required 00000200", busAddress);
    end
`else
    if (busAddress !== 32'h340) begin
      bad++;
      $display("FAIL tie_first_grant addr=%h required 00000340", busAddress);
    end
`endif
    wait_drain("tie", 20);
  endtask

  task automatic test_fetch_kill();
    int fp;
    fp = fetch_pulses;
    resp_delay = 2;
    fetchAddress = 32'h380;
    fetchRequest = 1'b1;
    @(negedge clock);
    @(negedge clock);
    total++;
    if (busRequest !== 1'b1 || busAddress !== 32'h380) begin
      bad++;
      $display("FAIL kill_issue busRequest=%b addr=%h required 1 00000380", busRequest, busAddress);
    end
    step(1);
    fetchKill = 1'b1;
    fetchRequest = 1'b0;
    step(1);
    fetchKill = 1'b0;
    step(5);
    total++;
    if (fetch_pulses - fp != 0) begin
      bad++;
      $display("FAIL kill_suppress fetchValid_pulses=%0d required 0", fetch_pulses - fp);
    end
    resp_delay = 0;
    fetchAddress = 32'h400;
    fetchRequest = 1'b1;
    fetchKill = 1'b1;
    step(1);
    fetchKill = 1'b0;
    @(negedge clock);
    total++;
    if (busRequest !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle_drop busRequest=%b required 0", busRequest);
    end
    sb.push_back(exp_t'{0, mem_word(32'h400)});
    wait_drain("after_kill", 10);
  endtask

  task automatic test_store_and_load();
    addressRegister = 32'h500;
    storeData = 32'h1122_3344;
    realStoreByteEnable = 4'b1111;
    storeValid = 1'b1;
    dataReadRequest = 1'b1;
    sb.push_back(exp_t'{2, 32'h0});
    sb.push_back(exp_t'{1, mem_word(32'h500)});
    @(negedge clock);
    @(negedge clock);
    total++;
    if ({busRequest, busWrite, busAddress, busWriteData} !== {1'b1, 1'b1, 32'h500, 32'h1122_3344}) begin
      bad++;
      $display("FAIL both_store_first got=%b %b %h %h required 1 1 00000500 11223344", busRequest, busWrite, busAddress, busWriteData);
    end
    repeat (4) @(negedge clock);
    total++;
    if ({busRequest, busWrite, busAddress, busByteEnable} !== {1'b1, 1'b0, 32'h500, 4'b1111}) begin
      bad++;
      $display("FAIL both_load_second got=%b %b %h %b required 1 0 00000500 1111", busRequest, busWrite, busAddress, busByteEnable);
    end
    wait_drain("store_load", 15);
    realStoreByteEnable = 4'b0000;
  endtask

  task automatic test_stray_response();
    int pulses;
    pulses = fetch_pulses + load_pulses + store_pulses;
    stray = 1;
    step(4);
    total++;
    if (fetch_pulses + load_pulses + store_pulses != pulses ||
        fetchInstruction !== mem_word(32'h400) || loadData !== mem_word(32'h500)) begin
      bad++;
      $display("FAIL stray_ignored pulses=%0d fetch=%h load=%h required 0 %h %h",
               fetch_pulses + load_pulses + store_pulses - pulses, fetchInstruction, loadData,
               mem_word(32'h400), mem_word(32'h500));
    end
  endtask

  task automatic test_reset_mid();
    int lp;
    resp_delay = 3;
    addressRegister = 32'h600;
    dataReadRequest = 1'b1;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({busRequest, busWrite, busAddress, busWriteData, busByteEnable, fetchInstruction, loadData,
         fetchValid, loadDataValid, storeComplete} !== 137'h0) begin
      bad++;
      $display("FAIL reset_mid busAddress=%h fetch=%h load=%h busRequest=%b required all zero",
               busAddress, fetchInstruction, loadData, busRequest);
    end
    dataReadRequest = 1'b0;
    resp_delay = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(1);
    lp = load_pulses;
    addressRegister = 32'h10;
    dataReadRequest = 1'b1;
    sb.push_back(exp_t'{1, 32'hDEAD_BEEF});
    wait_drain("after_reset", 10);
    total++;
    if (load_pulses - lp != 1) begin
      bad++;
      $display("FAIL after_reset_pulses got=%0d required 1", load_pulses - lp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fetchRequest = 1'b0;
    fetchKill = 1'b0;
    dataReadRequest = 1'b0;
    storeValid = 1'b0;
    fetchAddress = 32'h0;
    addressRegister = 32'h0;
    storeData = 32'h0;
    realStoreByteEnable = 4'b0000;
    test_reset();
    test_fetch_only();
    test_store_stall();
    test_tie();
    test_fetch_kill();
    test_store_and_load();
    test_stray_response();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
